// File: rtl/mux2_sel_arbiter_if.sv
// Source/sink bundle between the two valid/ready sources, the output stage and the mux select.
// The master modport is the arbiter's view; slave is the surrounding environment.
interface mux2_sel_arbiter_if #(
  parameter int WIDTH = 8
);
  logic             a_valid;
  logic             a_ready;
  logic [WIDTH-1:0] a_data;
  logic             b_valid;
  logic             b_ready;
  logic [WIDTH-1:0] b_data;
  logic             sel;
  logic             y_valid;
  logic             y_ready;
  logic [WIDTH-1:0] y_data;

  modport master (
    input  a_valid, a_data, b_valid, b_data, y_ready,
    output a_ready, b_ready, sel, y_valid, y_data
  );

  modport slave (
    output a_valid, a_data, b_valid, b_data, y_ready,
    input  a_ready, b_ready, sel, y_valid, y_data
  );
endinterface

// File: rtl/mux2_sel_arbiter.sv
// Bounded round-robin arbiter driving the select S of a downstream 2:1 transmission-gate mux.
// Define MUX2_SEL_BBM_EN to insert a one-cycle break-before-make SWITCH state between grants.
module mux2_sel_arbiter #(
  parameter int WIDTH    = 8,
  parameter int HOLD_MAX = 4
) (
  input logic                clk,
  input logic                rst,
  mux2_sel_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
`ifdef MUX2_SEL_BBM_EN
    ,
    SWITCH  = 2'd3
`endif
  } state_t;

  state_t           state_q, state_d, other_grant;
  logic [3:0]       hold_q, hold_d;
  logic             last_q, last_d;  // 1 = source B was served last
  logic             sel_q, sel_d;
  logic             y_valid_q;
  logic [WIDTH-1:0] y_data_q;

  logic out_ready, a_ready, b_ready;
  logic a_xfer, b_xfer, xfer;
  logic own_valid, other_valid, hold_last;

  assign out_ready = !y_valid_q || bus.y_ready;
  assign a_ready   = (state_q == GRANT_A) && out_ready;
  assign b_ready   = (state_q == GRANT_B) && out_ready;
  assign a_xfer    = bus.a_valid && a_ready;
  assign b_xfer    = bus.b_valid && b_ready;
  assign xfer      = a_xfer || b_xfer;

  // Seen from the current grant: "own" is the granted source, "other" the waiting one.
  assign own_valid   = (state_q == GRANT_B) ? bus.b_valid : bus.a_valid;
  assign other_valid = (state_q == GRANT_B) ? bus.a_valid : bus.b_valid;
  assign other_grant = (state_q == GRANT_B) ? GRANT_A : GRANT_B;
  // >= rather than == so a saturated run still yields once the other source shows up.
  assign hold_last   = hold_q >= 4'(HOLD_MAX - 1);

  always_comb begin
    // NOTE: every signal gets its default first, so no branch can leave a latch behind.
    state_d = state_q;
    hold_d  = hold_q;
    sel_d   = sel_q;
    last_d  = last_q;

    if (xfer) last_d = b_xfer;

    case (state_q)
      IDLE: begin
        if (bus.a_valid && (!bus.b_valid || last_q)) begin
          state_d = GRANT_A;
          sel_d   = 1'b0;
          hold_d  = '0;
        end else if (bus.b_valid) begin
          state_d = GRANT_B;
          sel_d   = 1'b1;
          hold_d  = '0;
        end
      end

      GRANT_A, GRANT_B: begin
        if (xfer && hold_q != 4'(HOLD_MAX)) hold_d = hold_q + 4'd1;

        if (!own_valid && !other_valid) begin
          state_d = IDLE;
        end else if (other_valid && (!own_valid || (xfer && hold_last))) begin
          sel_d  = (state_q == GRANT_A);
          hold_d = '0;
`ifdef MUX2_SEL_BBM_EN
          state_d = SWITCH;
`else
          state_d = other_grant;
`endif
        end
      end

`ifdef MUX2_SEL_BBM_EN
      // sel already points at the new source; the grant follows unconditionally.
      SWITCH: begin
        state_d = sel_q ? GRANT_B : GRANT_A;
        hold_d  = '0;
      end
`endif

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
      last_q  <= 1'b1;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
    end
  end

  // Single-entry output stage; a beat held here at reset is simply dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_valid_q <= 1'b0;
      y_data_q  <= '0;
    end else if (xfer) begin
      y_valid_q <= 1'b1;
      y_data_q  <= a_xfer ? bus.a_data : bus.b_data;
    end else if (bus.y_ready) begin
      y_valid_q <= 1'b0;
    end
  end

  assign bus.a_ready = a_ready;
  assign bus.b_ready = b_ready;
  assign bus.sel     = sel_q;
  assign bus.y_valid = y_valid_q;
  assign bus.y_data  = y_data_q;

endmodule

// File: doc/mux2_sel_arbiter.md
# mux2_sel_arbiter

Sequential controller that sits directly upstream of the transistor-level 2:1 mux and drives its select input `S`. It arbitrates between two valid/ready sources A and B with bounded round-robin fairness and registers the winning beat into a single-entry output stage. `sel` changes only at defined state transitions, so the downstream transmission-gate mux never switches mid-beat. `sel`=0 routes A and `sel`=1 routes B, matching the mux polarity.

## Interface

Parameters:
- `WIDTH`, default 8: data width of each source and of the output.
- `HOLD_MAX`, default 4: maximum number of consecutive beats granted to one source while the other is requesting. Legal range is 1..15.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `a_valid`  input  1  source A has a beat.
- `a_ready`  output  1  beat from A accepted this cycle.
- `a_data`  input  WIDTH  source A payload.
- `b_valid`  input  1  source B has a beat.
- `b_ready`  output  1  beat from B accepted this cycle.
- `b_data`  input  WIDTH  source B payload.
- `sel`  output  1  registered select to the downstream mux `S`.
- `y_valid`  output  1  output register holds a beat.
- `y_ready`  input  1  downstream accepts the output beat.
- `y_data`  output  WIDTH  output register payload.

## Operation

- States are IDLE, GRANT_A, GRANT_B, and SWITCH. SWITCH exists only with the macro described under Configuration.
- `out_ready` = !`y_valid` || `y_ready`.
- `a_ready` = (state==GRANT_A) && `out_ready`.
- `b_ready` = (state==GRANT_B) && `out_ready`.
- A transfer occurs when valid and ready are both high. The output register loads the source data and sets `y_valid`.
- When `y_valid` && `y_ready` and no new transfer occurs, `y_valid` clears. `y_data` holds its last value.
- `last` register records the last-served source. It resets to B, so A wins the first tie.
- IDLE transitions:
  - Only A valid: go to GRANT_A.
  - Only B valid: go to GRANT_B.
  - Both valid: grant the source opposite to `last`.
  - Neither valid: stay in IDLE.
  - IDLE accepts no beats.
- GRANT_X, with Y the other source:
  - `hold` counts transfers from X. Width is 4 bits, and it resets to 0 on every entry to a GRANT state.
  - Switch to Y on the edge where `hold`+1==HOLD_MAX and a transfer occurs and `y_valid` of Y is high.
  - Also switch to Y when `x_valid`=0 and `y_valid` of Y =1.
  - Go to IDLE when both valids are low. `sel` keeps its value.
  - Otherwise stay in GRANT_X. If only X is requesting, `hold` saturates at HOLD_MAX and the grant continues.
- `sel` updates on the same edge that enters GRANT_B (or SWITCH toward B), going to 1. It updates symmetrically toward A, going to 0.
- `sel` never changes while in a GRANT state except on that exit edge.
- `last` updates on every transfer.
- Reset mid-operation: any beat held in the output register is dropped, with no partial handshake. Sources must re-present their data.

## Timing

- Reset values: `a_ready`=0, `b_ready`=0, `sel`=0, `y_valid`=0, `y_data`=0, state=IDLE, `hold`=0, `last`=B.
- Latency from an accepted beat at edge N to `y_valid`/`y_data` is 1 cycle: the values are visible after edge N.
- Throughput is 1 beat/cycle from one source while `y_ready` stays high.
- IDLE to first grant costs 1 cycle with no ready asserted.
- A switch forced by HOLD_MAX costs 0 bubble cycles without the macro and 1 bubble cycle with it.
- A switch caused by the granted source dropping valid costs 1 bubble cycle, plus 1 more with the macro.
- Backpressure: while `y_valid`=1 and `y_ready`=0, both readies are 0 and state/`sel` hold. One exception: the switch and IDLE transitions that need no transfer may still occur.

## Configuration

- Macro `MUX2_SEL_BBM_EN` adds a break-before-make cycle.
- Defined: every GRANT_A↔GRANT_B transition passes through SWITCH for exactly 1 cycle.
  - `sel` changes on the edge entering SWITCH.
  - Both readies are 0 in SWITCH.
  - SWITCH always proceeds to the new grant state, even if its valid has dropped. That grant state then follows the normal rules.
- Undefined: SWITCH is not built. Transitions go directly between GRANT_A and GRANT_B, and `sel` changes on that edge.

## Test plan

- Reset: assert `rst` asynchronously mid-stream with `y_valid`=1. Required: `y_valid`, `sel`, `a_ready`, and `b_ready` read 0 immediately without a clock edge. State is IDLE after release.
- Single source: A streams beats 0x11..0x18 with `y_ready`=1 and B idle. Required: 8 consecutive `y_data` beats, 1-cycle latency, `sel`=0 throughout, `hold` saturated at 4.
- Fairness: A and B are both continuously valid, HOLD_MAX=4. Required: beat pattern AAAABBBBAAAA.
  - Without the macro: no bubbles.
  - With `MUX2_SEL_BBM_EN`: one ready-low cycle per switch, with `sel` toggling at the start of that cycle.
- Backpressure: hold `y_ready`=0 for 3 cycles mid-stream. Required: readies are 0 during the stall, `y_data` is stable, no beat is lost or duplicated, and streaming resumes on release.
- Tie from IDLE: A and B become valid simultaneously after reset. Required: A is granted first (`sel`=0) and B second.
- Source drop: A deasserts `a_valid` while B is valid. Required: one bubble cycle, then `sel`=1 and B is granted. With the macro there is one additional SWITCH cycle.
